// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the round controller.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Plaintext, round-key and ciphertext signalling between wrapper, key store and controller.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic [3:0]           rk_idx;
  logic [AES_BLK_W-1:0] rk_data;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;

  modport master (
    output in_valid, in_data, rk_data, abort, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, rk_data, abort, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round; last skips MixColumns.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 last,
  output logic [AES_BLK_W-1:0] state_nx
);

  logic [AES_BLK_W-1:0] sr;
  logic [AES_BLK_W-1:0] mc;

  // Byte i sits at row i%4, column i/4; row r takes its byte from column (c+r)%4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R   = i % 4;
    localparam int C   = i / 4;
    localparam int SRC = R + 4 * ((C + R) % 4);
    assign sr[127-8*i -: 8] = sbox(state[127-8*SRC -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
  end

  assign state_nx = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller; optional debug ports with AES_ROUND_CTRL_DBG_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_round_ctrl_if.slave bus
`ifdef AES_ROUND_CTRL_DBG_EN
  ,
  output logic [3:0]     dbg_round,
  output logic [1:0]     dbg_fsm
`endif
);

  fsm_e                 fsm, fsm_nx;
  logic [3:0]           round, round_nx;
  logic [AES_BLK_W-1:0] state, state_nx, rnd_out;
  logic                 last;

  assign last = (round == 4'(NR));

  aes_round_comb u_round (
    .state    (state),
    .rk       (bus.rk_data),
    .last     (last),
    .state_nx (rnd_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      round <= '0;
      state <= '0;
    end else begin
      fsm   <= fsm_nx;
      round <= round_nx;
      state <= state_nx;
    end
  end

  always_comb begin
    fsm_nx   = fsm;
    round_nx = round;
    state_nx = state;
    unique case (fsm)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx = bus.in_data ^ bus.rk_data;
          round_nx = 4'd1;
          fsm_nx   = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = rnd_out;
          round_nx = '0;
          fsm_nx   = DONE;
        end else if (round == '0 || round > 4'(NR)) begin
          round_nx = '0;
          fsm_nx   = IDLE;
        end else begin
          state_nx = rnd_out;
          round_nx = round + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_nx = IDLE;
      end
      default: begin
        round_nx = '0;
        fsm_nx   = IDLE;
      end
    endcase
    // Abort overrides any handshake and leaves the datapath register untouched.
    if (bus.abort) begin
      fsm_nx   = IDLE;
      round_nx = '0;
      state_nx = state;
    end
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.out_valid = (fsm == DONE);
  assign bus.rk_idx    = round;
  assign bus.out_data  = state;

`ifdef AES_ROUND_CTRL_DBG_EN
  assign dbg_round = round;
  assign dbg_fsm   = fsm;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench: independent AES model, key store, directed FIPS vectors and random traffic.
module tb_aes_round_ctrl;

  localparam int unsigned NR = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus();

`ifdef AES_ROUND_CTRL_DBG_EN
  logic [3:0] dbg_round;
  logic [1:0] dbg_fsm;
`endif

  aes_round_ctrl #(.NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef AES_ROUND_CTRL_DBG_EN
    ,
    .dbg_round (dbg_round),
    .dbg_fsm   (dbg_fsm)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [127:0] rkeys  [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse plus affine map, independent of any table.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = '0;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rkeys[0];
    for (int r = 1; r <= int'(NR); r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q+4*c] = s[q+4*((c+q)%4)];
      if (r != int'(NR)) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a [4];
          for (int q = 0; q < 4; q++) a[q] = t[4*c+q];
          for (int q = 0; q < 4; q++)
            t[4*c+q] = gmul(a[q], 8'h02) ^ gmul(a[(q+1)%4], 8'h03) ^ a[(q+2)%4] ^ a[(q+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      v ^= rkeys[r];
    end
    return v;
  endfunction

  // Key store answers combinationally.
  assign bus.rk_data = (bus.rk_idx <= 4'd10) ? rkeys[bus.rk_idx] : '0;

  // Timeline: 0 idle, 1..NR running with that key index, NR+1 holding ciphertext.
  int           phase = 0;
  int           cyc   = 0;
  logic [127:0] m_ct  = '0;
  int           acc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= 0;
    else if (bus.abort) phase <= 0;
    else if (phase == 0) begin
      if (bus.in_valid) begin
        phase <= 1;
        m_ct  <= encrypt(bus.in_data);
        acc_log.push_back(cyc);
      end
    end else if (phase <= int'(NR)) phase <= phase + 1;
    else if (bus.out_ready) phase <= 0;
  end

  always @(negedge clk) begin
    chk("cyc_in_ready", 128'(bus.in_ready), 128'(phase == 0));
    chk("cyc_out_valid", 128'(bus.out_valid), 128'(phase == int'(NR) + 1));
    chk("cyc_rk_idx", 128'(bus.rk_idx), 128'((phase >= 1 && phase <= int'(NR)) ? phase : 0));
    if (phase == int'(NR) + 1) chk("cyc_out_data", bus.out_data, m_ct);
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] E0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_wait"}, 128'(bus.in_ready), 128'(1));
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_out_wait"}, 128'(bus.out_valid), 128'(1));
  endtask

  task automatic do_block(input string name, input logic [127:0] pt, input logic [127:0] ct,
                          input bit trace_rk, input bit chk_e0, input logic [127:0] e0);
    int lat;
    wait_idle(name);
    bus.in_valid  = 1'b1;
    bus.in_data   = pt;
    bus.out_ready = 1'b1;
    if (trace_rk) chk({name, "_rk0"}, 128'(bus.rk_idx), 128'(0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (chk_e0) chk({name, "_state_e0"}, dut.state, e0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (trace_rk) chk($sformatf("%s_rk%0d", name, lat + 1), 128'(bus.rk_idx), 128'(lat + 1));
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 128'(lat), 128'(NR));
    chk({name, "_ct"}, bus.out_data, ct);
  endtask

  initial begin
    int           n;
    int           gap;
    logic [127:0] pt2;
    logic [127:0] ct2;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    build_sbox();
    load_key(KEY_B);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'(0));
    rst_n = 1'b1;

    chk("model_sbox53", 128'(sbox_m[8'h53]), 128'(8'hed));
    chk("model_e0", PT_B ^ rkeys[0], E0_B);
    chk("model_appB", encrypt(PT_B), CT_B);

    do_block("appB", PT_B, CT_B, 1'b0, 1'b1, E0_B);

    load_key(KEY_C);
    chk("model_appC", encrypt(PT_C), CT_C);
    do_block("appC", PT_C, CT_C, 1'b1, 1'b0, '0);

    // Output stall
    load_key(KEY_B);
    wait_idle("stall");
    bus.in_valid  = 1'b1;
    bus.in_data   = PT_B;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out("stall", n);
    chk("stall_latency", 128'(n), 128'(NR));
    repeat (20) begin
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_out_data", bus.out_data, CT_B);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", 128'(bus.in_ready), 128'(1));
    chk("stall_release_out_valid", 128'(bus.out_valid), 128'(0));

    // Abort in IDLE blocks the accept
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = PT_B;
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_idle_in_ready", 128'(bus.in_ready), 128'(1));
    chk("abort_idle_rk_idx", 128'(bus.rk_idx), 128'(0));

    // Abort at round 5
    bus.in_valid = 1'b1;
    bus.in_data  = PT_B;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_round5", 128'(bus.rk_idx), 128'(5));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
    chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_rk_idx", 128'(bus.rk_idx), 128'(0));
    do_block("after_abort", PT_B, CT_B, 1'b0, 1'b0, '0);

    // Reset mid-RUN
    wait_idle("rst_run");
    bus.in_valid = 1'b1;
    bus.in_data  = PT_B;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx != 4'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_run_reach_round3", 128'(bus.rk_idx), 128'(3));
    rst_n = 1'b0;
    #1;
    chk("rst_run_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_run_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_run_out_data", bus.out_data, 128'(0));
    chk("rst_run_rk_idx", 128'(bus.rk_idx), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back with in_valid held high
    pt2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    ct2 = encrypt(pt2);
    wait_idle("b2b");
    acc_log.delete();
    bus.in_valid  = 1'b1;
    bus.in_data   = PT_B;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_data = pt2;
    wait_out("b2b_first", n);
    chk("b2b_first_ct", bus.out_data, CT_B);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out("b2b_second", n);
    chk("b2b_second_ct", bus.out_data, ct2);
    chk("b2b_accepts", 128'(acc_log.size()), 128'(2));
    gap = (acc_log.size() >= 2) ? acc_log[1] - acc_log[0] : -1;
    chk("b2b_interval", 128'(gap), 128'(12));
    @(negedge clk);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (phase == 0 && $urandom_range(0, 15) == 0)
        load_key({$urandom(), $urandom(), $urandom(), $urandom()});
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.abort     = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption controller that sequences the round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) over one 128-bit state register for 10 rounds. It accepts a plaintext block on a valid/ready handshake and requests round keys by index from the key-expansion block. It returns the ciphertext on a second valid/ready handshake. It sits between the block-level wrapper and the shared round-key store.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128, exposed for test only.

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext block present.
- in_ready  out  1  controller can accept a block.
- in_data  in  128  plaintext; [127:120] = byte 0, column-major (column 0 = [127:96]).
- rk_idx  out  4  round-key index requested (0..10).
- rk_data  in  128  round key for rk_idx, valid combinationally in the same cycle.
- abort  in  1  synchronous cancel of the current block.
- out_valid  out  1  ciphertext present.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext, same byte order as in_data.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1 and rk_idx=0.
  - On in_valid&&in_ready: state <= in_data ^ rk_data, round <= 1, next state RUN.
- RUN
  - rk_idx = round.
  - Each cycle: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_data).
  - When round==NR, MixColumns is skipped and the FSM moves to DONE.
  - Otherwise round <= round+1.
- DONE
  - out_valid=1; out_data=state, held stable until out_ready.
  - On out_valid&&out_ready: next state IDLE.
- round is a 4-bit counter: 0 in IDLE/DONE, 1..10 in RUN. It never wraps; values 11..15 are unreachable and decode to IDLE.
- in_ready is 0 in RUN and DONE; in_valid is ignored there.
- abort=1 in any state: next state IDLE, round <= 0, out_valid drops, state is not cleared. abort takes priority over every handshake in the same cycle. An abort in IDLE with in_valid=1 blocks the accept.
- Reset (any time, including mid-RUN) asynchronously forces IDLE, round=0, state=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, rk_idx=0.
- Let edge E0 be the accept edge.
  - Edges E1..E10 perform rounds 1..10.
  - out_valid rises after E10, i.e. 10 cycles after E0, with no bubble.
- Minimum initiation interval is 12 cycles: accept, 10 rounds, 1 DONE cycle with out_ready=1. in_ready returns the cycle after the output handshake.
- Output stalls are unbounded. out_data is stable while out_valid=1 and out_ready=0.
- rk_data is sampled at the same edge that uses it. The key store must respond combinationally to rk_idx.

## Configuration
- AES_ROUND_CTRL_DBG_EN defined: adds output ports dbg_round (4 bits, the round counter) and dbg_fsm (2 bits: IDLE=0, RUN=1, DONE=2), both driven directly from registers.
- Not defined: these ports and their logic do not exist. Functional behaviour is identical in both builds.

## Structure
- Package aes_pkg holds:
  - the FSM state enum;
  - constants AES_NR=10 and AES_BLK_W=128;
  - the S-box function and the xtime/MixColumns helper functions.
- One sub-module, aes_round_comb, is purely combinational. Its inputs are state, rk, and a last flag that bypasses MixColumns. Its output is the next state. The ShiftRows mapping in it is row r rotated left by r bytes under the column-major layout.
- The controller owns only the FSM, the round counter and the state register.

## Test plan
- FIPS-197 App. B:
  - Stimulus: in_data=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1.
  - Required: state after E0 = 193de3bea0f4e22b9ac68d2ae9f84808; out_valid 10 cycles after accept; out_data=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1:
  - Stimulus: in_data=00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a; rk_idx sequence 0,1,…,10.
- Output stall:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_data and out_valid stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Abort:
  - Stimulus: abort at round 5.
  - Required: next cycle in_ready=1, out_valid=0. A following App. B block still yields 3925841d….
- Reset mid-RUN:
  - Stimulus: rst_n low at round 3.
  - Required: immediately in_ready=1, out_valid=0, out_data=0, rk_idx=0.
- Back-to-back:
  - Stimulus: in_valid held high with two blocks, out_ready=1.
  - Required: second accept exactly 12 cycles after the first; both ciphertexts correct.
